// File: rtl/div_sched.sv
// Round-robin scheduler sharing one 5-bit sequential divider between NREQ requesters.
// Optional DIV_ZERO_BYPASS_EN: divisor-0 grants skip the divider and return an error result.
`timescale 1ns/1ps
module div_sched #(
   parameter int              NREQ    = 4,
   parameter int              TO_W    = 20,
   parameter logic [TO_W-1:0] TIMEOUT = 20'd200000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [5*NREQ-1:0] a_in,
   input  logic [5*NREQ-1:0] b_in,
   output logic [NREQ-1:0]   done,
   output logic [4:0]        q_out,
   output logic [4:0]        r_out,
   output logic              err,
   output logic              busy,
   output logic              div_start,
   output logic [4:0]        div_a,
   output logic [4:0]        div_b,
   input  logic [4:0]        div_q,
   input  logic [4:0]        div_r,
   input  logic              div_ok
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_CAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [NREQ-1:0] ONE     = NREQ'(1);
   localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - 1'b1;

   logic [2:0]      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   id;
   logic [TO_W-1:0] wdog;

   logic            gnt_found;
   logic [IW-1:0]   gnt_id;
   logic [IW-1:0]   ptr_next;
   logic [4:0]      a_sel;
   logic [4:0]      b_sel;

   // First pending request at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr) + k) % NREQ;
         if (!gnt_found && req[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = IW'(idx);
         end
      end
   end

   always_comb begin
      a_sel    = a_in[5*int'(gnt_id) +: 5];
      b_sel    = b_in[5*int'(gnt_id) +: 5];
      ptr_next = (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         id        <= '0;
         wdog      <= '0;
         done      <= '0;
         q_out     <= '0;
         r_out     <= '0;
         err       <= 1'b0;
         div_start <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
      end else begin
         done <= '0;
         case (state)
            S_IDLE: begin
               if (gnt_found) begin
                  div_a <= a_sel;
                  div_b <= b_sel;
                  id    <= gnt_id;
                  ptr   <= ptr_next;
                  wdog  <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                  if (b_sel == 5'd0) begin
                     q_out <= '1;
                     r_out <= a_sel;
                     err   <= 1'b1;
                     done  <= ONE << gnt_id;
                     state <= S_DONE;
                  end else begin
                     div_start <= 1'b1;
                     state     <= S_ARM;
                  end
`else
                  div_start <= 1'b1;
                  state     <= S_ARM;
`endif
               end
            end
            S_ARM, S_RUN: begin
               // Watchdog wins over a same-cycle handshake so the abort bound is exact.
               if (wdog == WD_LAST) begin
                  div_start <= 1'b0;
                  q_out     <= '0;
                  r_out     <= '0;
                  err       <= 1'b1;
                  done      <= ONE << id;
                  state     <= S_DONE;
               end else begin
                  wdog <= wdog + 1'b1;
                  if (state == S_ARM && !div_ok)
                     state <= S_RUN;
                  else if (state == S_RUN && div_ok)
                     state <= S_CAP;
               end
            end
            S_CAP: begin
               q_out     <= div_q;
               r_out     <= div_r;
               err       <= 1'b0;
               div_start <= 1'b0;
               done      <= ONE << id;
               state     <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched with a behavioural slow-divider model and round-robin reference.
`timescale 1ns/1ps
module tb_div_sched;

   localparam int NREQ = 4;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req   = '0;
   logic [4:0]        A [NREQ];
   logic [4:0]        B [NREQ];
   logic [5*NREQ-1:0] a_in, b_in;
   logic [NREQ-1:0]   done;
   logic [4:0]        q_out, r_out, div_a, div_b;
   logic              err, busy, div_start;
   logic [4:0]        div_q  = '0;
   logic [4:0]        div_r  = '0;
   logic              div_ok = 1'b1;

   int dm_cnt = 0, dm_l1 = 2, dm_l2 = 6, start_cycles = 0;
   bit dm_hang = 1'b0;
   int n_tests = 0, n_fail = 0, exp_ptr = 0;

   always #5 clk = ~clk;

   always_comb begin
      a_in = '0;
      b_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         a_in[5*i +: 5] = A[i];
         b_in[5*i +: 5] = B[i];
      end
   end

   div_sched #(.NREQ(NREQ), .TO_W(20), .TIMEOUT(20'd64)) dut (
      .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
      .done(done), .q_out(q_out), .r_out(r_out), .err(err), .busy(busy),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_ok(div_ok)
   );

   // Divider result convention: x/0 yields all-ones quotient and the dividend as remainder.
   function automatic logic [9:0] ref_div(input logic [4:0] a, input logic [4:0] b);
      if (b == 5'd0) return {5'h1F, a};
      return {a / b, a % b};
   endfunction

   function automatic int winner(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   // Slow divider: loads dm_l1 cycles after start, result ready dm_l2 cycles later.
   always @(posedge clk) begin
      if (!div_start || dm_hang) begin
         dm_cnt <= 0;
         div_ok <= 1'b1;
      end else begin
         dm_cnt <= dm_cnt + 1;
         if (dm_cnt == dm_l1)
            div_ok <= 1'b0;
         else if (dm_cnt == dm_l1 + dm_l2) begin
            div_ok <= 1'b1;
            {div_q, div_r} <= ref_div(div_a, div_b);
         end
      end
   end

   always @(posedge clk) if (div_start) start_cycles <= start_cycles + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (3) @(negedge clk);
      reset   = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic serve(input int exp_id, input bit to, input bit drop, input string tag);
      bit              got;
      int              lat;
      logic [9:0]      qr;
      logic [NREQ-1:0] oh;
      logic            exp_err;
      qr      = ref_div(A[exp_id], B[exp_id]);
      exp_err = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      if (B[exp_id] == 5'd0) exp_err = 1'b1;
`endif
      if (to) begin
         qr      = '0;
         exp_err = 1'b1;
      end
      oh         = '0;
      oh[exp_id] = 1'b1;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 300) begin
         @(negedge clk);
         lat++;
         if (done != '0) got = 1'b1;
      end
      chk({tag, " reached_done"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, " done"}, 32'(done), 32'(oh));
         chk({tag, " q"}, 32'(q_out), 32'(qr[9:5]));
         chk({tag, " r"}, 32'(r_out), 32'(qr[4:0]));
         chk({tag, " err"}, 32'(err), 32'(exp_err));
         if (to) begin
            chk({tag, " latency"}, 32'(lat), 32'd65);
            chk({tag, " div_start"}, 32'(div_start), 32'd0);
         end
         if (drop) req[exp_id] = 1'b0;
         @(negedge clk);
         chk({tag, " done_width"}, 32'(done), 32'd0);
         chk({tag, " busy_after"}, 32'(busy), 32'd0);
         chk({tag, " q_held"}, 32'(q_out), 32'(qr[9:5]));
      end
      exp_ptr = (exp_id + 1) % NREQ;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      int          ord [4];
      int          sc0;
      bit          found;
      logic [10:0] ro;

      ord = '{0, 1, 3, 0};
      for (int i = 0; i < NREQ; i++) begin
         A[i] = '0;
         B[i] = 5'd1;
      end

      // Reset values
      repeat (3) @(negedge clk);
      ro = {done[0], q_out, r_out};
      chk("rst done_q_r", 32'(ro), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst div_start", 32'(div_start), 32'd0);
      chk("rst div_ab", 32'({div_a, div_b}), 32'd0);
      reset = 1'b0;

      // Basic divide 23/4
      A[0] = 5'd23; B[0] = 5'd4; dm_l1 = 2; dm_l2 = 6;
      req = 4'b0001;
      serve(0, 1'b0, 1'b1, "div23_4");

      // Held requests 1011 from pointer 0
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         A[i] = 5'($urandom_range(0, 31));
         B[i] = 5'($urandom_range(0, 31));
      end
      A[1] = 5'd31; B[1] = 5'd5;
      req = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         dm_l1 = $urandom_range(1, 5);
         dm_l2 = $urandom_range(1, 20);
         serve(ord[i], 1'b0, 1'b0, "arb");
      end
      req = '0;

      // Hung divider
      dm_hang = 1'b1;
      A[2] = 5'($urandom_range(0, 31)); B[2] = 5'($urandom_range(1, 31));
      req = 4'b0100;
      serve(2, 1'b1, 1'b1, "watchdog");
      dm_hang = 1'b0;

      // Reset during S_RUN
      A[3] = 5'($urandom_range(0, 31)); B[3] = 5'($urandom_range(1, 31));
      dm_l1 = 1; dm_l2 = 30;
      req = 4'b1000;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (busy && !div_ok) found = 1'b1;
      end
      chk("midrst reached_run", 32'(found), 32'd1);
      @(negedge clk);
      chk("midrst busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      chk("midrst div_start", 32'(div_start), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      reset   = 1'b0;
      exp_ptr = 0;
      A[1] = 5'($urandom_range(0, 31)); B[1] = 5'($urandom_range(1, 31));
      dm_l1 = 3; dm_l2 = 5;
      req = 4'b0010;
      serve(1, 1'b0, 1'b1, "post_rst");

      // Divide by zero
      A[0] = 5'd9; B[0] = 5'd0;
      sc0 = start_cycles;
      req = 4'b0001;
      serve(0, 1'b0, 1'b1, "divzero");
`ifdef DIV_ZERO_BYPASS_EN
      chk("divzero start_cycles", 32'(start_cycles - sc0), 32'd0);
`else
      chk("divzero start_seen", 32'(start_cycles != sc0), 32'd1);
`endif

      // Request withdrawn after one cycle
      A[2] = 5'd10; B[2] = 5'd3;
      dm_l1 = 2; dm_l2 = 4;
      req = 4'b0100;
      @(negedge clk);
      req = '0;
      serve(2, 1'b0, 1'b0, "withdrawn");
      for (int i = 0; i < NREQ; i++) begin
         A[i] = 5'($urandom_range(0, 31));
         B[i] = 5'($urandom_range(0, 31));
      end
      req = 4'b1011;
      serve(3, 1'b0, 1'b1, "ptr_after_withdraw");
      for (int k = 0; k < NREQ; k++)
         if (req != '0) serve(winner(req, exp_ptr), 1'b0, 1'b1, "drain");

      // Random request patterns and operands
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < NREQ; i++) begin
            A[i] = 5'($urandom_range(0, 31));
            B[i] = 5'($urandom_range(0, 31));
         end
         req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int k = 0; k < NREQ; k++) begin
            if (req != '0) begin
               dm_l1 = $urandom_range(1, 5);
               dm_l2 = $urandom_range(1, 20);
               serve(winner(req, exp_ptr), 1'b0, 1'b1, "rand");
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
